// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed hex display scanner.
// Width helper, anode-off pattern and parameter legality check.
package seg_scan_pkg;

    localparam int NIBBLE_W = 4;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // All anodes off: n ones, right-aligned in 32 bits.
    function automatic logic [31:0] anode_off(input int n);
        if (n >= 32) return '1;
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic bit params_ok(
        input int nd,
        input int div,
        input int dead,
        input int blank
    );
        return (nd >= 1) && (nd <= 32) && (div >= 2) &&
               (dead >= 0) && (dead < div) &&
               (blank == 0 || blank == 1);
    endfunction

endpackage

// File: rtl/seg_refresh_divider.sv
// Slot timer for the scanner: divides clk into digit slots
// and walks the scanned digit index around the frame.
module seg_refresh_divider
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 4,
    localparam int CNT_W = clog2(REFRESH_DIV),
    localparam int IDX_W = clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] div_cnt,
    output logic [IDX_W-1:0] idx,
    output logic             tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign tick = (div_cnt_q == CNT_LAST);

    // Next slot count and digit index; index moves once per slot.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
        end
    end

    assign div_cnt = div_cnt_q;
    assign idx     = idx_q;

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexes a packed hex value onto one digit bus with
// active-low anodes, dead-time, leading-zero blanking and frame-safe loads.
module seg_digit_scanner
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int DEAD_CYCLES   = 16,
    parameter int BLANK_LEADING = 1,
    localparam int IDX_W  = clog2(NUM_DIGITS),
    localparam int DATA_W = NIBBLE_W * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_W-1:0]     load_data,
    output logic [NIBBLE_W-1:0]   nibble_out,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  blank_out
);

    localparam int CNT_W = clog2(REFRESH_DIV);
    localparam logic [31:0] AN_OFF_W = anode_off(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_OFF_W[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam bit BLANK_EN = (BLANK_LEADING != 0);

    if (!params_ok(NUM_DIGITS, REFRESH_DIV, DEAD_CYCLES, BLANK_LEADING))
    begin : g_bad_params
        $error("seg_digit_scanner: illegal parameter combination");
    end

    logic [CNT_W-1:0] div_cnt;
    logic [IDX_W-1:0] idx;
    logic             tick;

    seg_refresh_divider #(
        .REFRESH_DIV (REFRESH_DIV),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_cnt (div_cnt),
        .idx     (idx),
        .tick    (tick)
    );

    logic [DATA_W-1:0]     display_q, display_d;
    logic [DATA_W-1:0]     pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [NIBBLE_W-1:0]   nibble_q, nibble_d;
    logic [IDX_W-1:0]      digit_idx_q;
    logic                  blank_q, blank_d;

    logic                  in_dead;
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  accept;
    logic                  commit;

    if (DEAD_CYCLES == 0) begin : g_no_dead
        assign in_dead = 1'b0;
    end else begin : g_dead
        localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD_CYCLES);
        assign in_dead = (div_cnt < DEAD_C);
    end

    // zero_from[i]: every nibble at index i and above is zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run && (display_q[NIBBLE_W*i +: NIBBLE_W] == '0);
            zero_from[i] = run;
        end
    end

    assign accept = load_valid && !pending_valid_q;
    assign commit = tick && (idx == IDX_LAST) && pending_valid_q;

    // Load capture, frame-end commit and next output values.
    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        display_d       = display_q;
        if (accept) begin
            pending_d       = load_data;
            pending_valid_d = 1'b1;
        end else if (commit) begin
            display_d       = pending_q;
            pending_valid_d = 1'b0;
        end
        blank_d  = BLANK_EN && (idx != '0) && zero_from[idx];
        nibble_d = display_q[NIBBLE_W*idx +: NIBBLE_W];
        an_n_d   = (in_dead || blank_d) ? AN_OFF : ~(AN_ONE << idx);
    end

    // Display/pending state and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q       <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            an_n_q          <= AN_OFF;
            nibble_q        <= '0;
            digit_idx_q     <= '0;
            blank_q         <= 1'b0;
        end else begin
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            an_n_q          <= an_n_d;
            nibble_q        <= nibble_d;
            digit_idx_q     <= idx;
            blank_q         <= blank_d;
        end
    end

    assign load_ready = !pending_valid_q;
    assign an_n       = an_n_q;
    assign nibble_out = nibble_q;
    assign digit_idx  = digit_idx_q;
    assign blank_out  = blank_q;

endmodule

// File: doc/seg_digit_scanner.md
Name: seg_digit_scanner

Overview:
- Upstream feeder for the per-segment decoders (segment_a … segment_g). Each decoder consumes a 4-bit digit on D3..D0 and drives one segment line.
- Holds a multi-digit hex value and time-multiplexes it onto one shared 4-bit digit bus. Drives active-low anode enables so all digits of the common-anode display share the segment lines.
- Loads new values through a valid/ready handshake and commits them only at frame boundaries, so the display never tears.
- Provides dead-time between digits (anti-ghosting) and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; digit NUM_DIGITS-1 is most significant.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be ≥ 2.
- DEAD_CYCLES, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- BLANK_LEADING, 1: 1 = suppress leading zero digits; 0 = show all digits.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- load_valid, in, 1: load_data is valid this cycle.
- load_ready, out, 1: block can accept a load.
- load_data, in, 4*NUM_DIGITS: packed nibbles; [3:0] = digit 0.
- nibble_out, out, 4: current digit value; bit 3 goes to D3 … bit 0 goes to D0 of the decoders.
- an_n, out, NUM_DIGITS: anode enables, active low, at most one bit low.
- digit_idx, out, clog2(NUM_DIGITS): index of the digit currently being scanned.
- blank_out, out, 1: current slot is blanked.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (applied immediately on rst_n low):
  - div_cnt = 0, idx = 0, display = 0, pending_valid = 0.
  - Outputs: an_n = all ones, nibble_out = 0, digit_idx = 0, blank_out = 0.
  - load_ready = 1.
- Refresh counter:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (div_cnt == REFRESH_DIV-1).
  - On tick, idx increments, wrapping NUM_DIGITS-1 → 0.
  - Frame = NUM_DIGITS*REFRESH_DIV cycles.
- Outputs are registered from the (div_cnt, idx, display) state of the previous cycle, i.e. one cycle of latency.
  - digit_idx = idx.
  - nibble_out = display[4*idx +: 4].
  - an_n:
    - all ones if div_cnt < DEAD_CYCLES, or if the digit is blanked;
    - otherwise all ones except bit idx = 0.
  - blank_out = 1 iff the digit is blanked; blank_out is independent of dead-time.
- Blanking:
  - Digit i (i > 0) is blanked iff BLANK_LEADING = 1 and every nibble at index ≥ i in display is zero.
  - Digit 0 is never blanked, so a value of 0 displays a single "0".
- Load handshake:
  - Transfer occurs when load_valid && load_ready; load_data is captured into pending and pending_valid is set to 1.
  - load_ready = !pending_valid, decoded from a register, with no combinational path from load_valid.
  - A load_valid asserted while load_ready = 0 is ignored. The upstream must hold load_valid until it sees ready.
- Commit:
  - When tick && idx == NUM_DIGITS-1 && pending_valid: display ← pending and pending_valid ← 0.
  - The new value appears starting at digit 0 of the next frame. load_ready returns to 1 the cycle after commit.
  - Commit and accept cannot coincide, because ready is low whenever pending is valid.
- Reset mid-operation: any pending load is discarded, display returns to 0 and anodes are off immediately.
- Worst-case load latency: one frame plus one cycle from transfer to the first displayed digit.

Decomposition:
- Package seg_scan_pkg holds:
  - the function clog2;
  - localparam NIBBLE_W = 4;
  - the ANODE_OFF constant generator (all-ones of NUM_DIGITS);
  - the parameter legality checks, as elaboration-time asserts.
- One sub-module, seg_refresh_divider, contains div_cnt, idx and tick. Its outputs are idx, div_cnt and tick.
- Blanking, commit and output registers stay in the top level.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, BLANK_LEADING=0 unless stated):
1. Reset, then release with no load → an_n = 1111 during reset. Then per slot: 1 cycle of 1111, then 3 cycles of 1110, 1101, 1011, 0111 in turn; digit_idx 0→3 wraps every 16 cycles; nibble_out = 0; load_ready = 1.
2. Load 16'h1234 at cycle 5 of a frame → load_ready falls the next cycle; the current frame still shows 0. In the next frame nibble_out = 4, 3, 2, 1 for idx 0..3. load_ready rises the cycle after the frame-end commit.
3. BLANK_LEADING=1, load 16'h0070 → idx 2 and 3 have an_n = 1111 and blank_out = 1; idx 1 shows 7; idx 0 shows 0 with blank_out = 0. Then load 16'h0000 → only digit 0 is lit, showing 0.
4. Load 16'hAAAA accepted, then assert load_valid with 16'hBBBB while load_ready = 0 for 3 cycles and drop it → display commits AAAA; BBBB is never shown; load_ready stays 0 until the commit.
5. rst_n pulsed low mid-slot with a pending load of 16'h5555 → an_n = 1111 without waiting for clk. After release, display = 0, load_ready = 1, and 5555 is never shown.
6. REFRESH_DIV=2, DEAD_CYCLES=0 corner case → no all-off cycle. The anode pattern advances every 2 cycles and wraps from 0111 to 1110 without a glitch; exactly one anode is low in every cycle.
